sequence_detector: RTL
======================

SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

Interface
REQ-001 The block SHALL take parameter PATTERN_LEN, default 2, giving the detected pattern length in bits (legal 2..16).
REQ-002 The block SHALL take parameter DEFAULT_PATTERN, default 2'b11, giving the pattern loaded at reset, PATTERN_LEN bits wide.
REQ-003 The block SHALL take parameter OVERLAP, default 1; 1 means overlapping matches are detected, 0 means non-overlapping.
REQ-004 The block SHALL take parameter CNT_W, default 8, giving the match counter width (legal 1..32).
REQ-005 Port clk: input, 1 bit; single clock, all state changes on its rising edge.
REQ-006 Port reset: input, 1 bit; asynchronous, active-high reset.
REQ-007 Port in: input, 1 bit; serial data bit.
REQ-008 Port in_valid: input, 1 bit; high when the `in` bit is accepted this cycle.
REQ-009 Port pattern: input, PATTERN_LEN bits; new pattern, with pattern[PATTERN_LEN-1] the first bit received.
REQ-010 Port pat_load: input, 1 bit; one-cycle strobe that loads `pattern`.
REQ-011 Port cnt_clr: input, 1 bit; synchronous clear of match_count.
REQ-012 Port out: output, 1 bit, registered; match pulse.
REQ-013 Port match_count: output, CNT_W bits, registered; saturating count of matches.

Function
REQ-014 The block SHALL hold pattern_reg (PATTERN_LEN bits), a history shift register hist (PATTERN_LEN-1 bits) and a fill counter fill (0..PATTERN_LEN-1).
REQ-015 On a cycle with in_valid=1 and pat_load=0, the candidate SHALL be {hist, in}, newest bit in the LSB.
REQ-016 A match SHALL be declared only when fill==PATTERN_LEN-1 and the candidate equals pattern_reg.
REQ-017 out SHALL go high on the clock edge that accepts the completing bit (Mealy decision, registered) and stay high for exactly one cycle per match.
REQ-018 out SHALL be 0 after any edge where in_valid=0, pat_load=1, or no match occurs; latency from the completing bit to out is 1 cycle.
REQ-019 With no match, an accepted bit SHALL shift into hist, and fill SHALL increment, saturating at PATTERN_LEN-1.
REQ-020 With a match and OVERLAP=1, hist SHALL shift normally and fill SHALL stay at PATTERN_LEN-1.
REQ-021 With a match and OVERLAP=0, hist and fill SHALL clear to 0, so the next match needs PATTERN_LEN fresh bits.
REQ-022 When in_valid=0, hist, fill and pattern_reg SHALL hold their values; gaps SHALL not break a partial sequence.
REQ-023 pat_load=1 SHALL load pattern_reg from `pattern` and clear hist and fill.
REQ-024 If pat_load=1 coincides with in_valid=1, the load SHALL win and the `in` bit SHALL be discarded.
REQ-025 Each match SHALL increment match_count by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-026 cnt_clr=1 SHALL set match_count to 0; if a match coincides with cnt_clr, the clear SHALL win (count 0) while out still pulses.
REQ-027 An all-zero or all-one pattern SHALL be legal and behave per REQ-016 to REQ-021.

Reset
REQ-028 While reset=1 (asynchronous, active-high): out=0, match_count=0, hist=0, fill=0, pattern_reg=DEFAULT_PATTERN.
REQ-029 A reset asserted mid-sequence SHALL discard the partial history; detection restarts from an empty history after release.
REQ-030 With default parameters, the block SHALL detect "11" with a registered one-cycle out pulse.

Verification
REQ-031 Defaults; in=0,1,1,1,0 with in_valid=1 -> out=1 on the edges after bits 3 and 4 only; match_count=2.
REQ-032 OVERLAP=0, LEN=2; in=1,1,1,1 -> out pulses after bits 2 and 4 only; match_count=2.
REQ-033 LEN=4; pat_load with pattern=4'b1011; then stream 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7 (overlap); count=2. With OVERLAP=0 -> only after bit 4.
REQ-034 Defaults; in=1, then in_valid=0 for 3 cycles, then in=1 -> out=1 once after the second valid bit; pat_load coinciding with a valid bit -> that bit is ignored and no match occurs.
REQ-035 CNT_W=2; 5 matches -> match_count=3 (saturated); cnt_clr on a match cycle -> count=0 and out=1.
REQ-036 Defaults; in=1, reset pulse, then in=1 -> no match; out=0 and match_count=0 during reset.

Source files
------------

// File: rtl/sequence_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern,
// optional overlap, and a saturating match counter.
//
// Ports:
//   clk         - clock, all state changes on rising edge
//   reset       - asynchronous active-high reset
//   in          - serial data bit
//   in_valid    - qualifies `in` this cycle
//   pattern     - new pattern, MSB is the first bit received
//   pat_load    - one-cycle strobe loading `pattern`
//   cnt_clr     - synchronous clear of match_count
//   out         - registered one-cycle match pulse
//   match_count - registered saturating match count
module sequence_detector #(
    parameter int                     PATTERN_LEN     = 2,
    parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = 2'b11,
    parameter bit                     OVERLAP         = 1'b1,
    parameter int                     CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in,
    input  logic                   in_valid,
    input  logic [PATTERN_LEN-1:0] pattern,
    input  logic                   pat_load,
    input  logic                   cnt_clr,
    output logic                   out,
    output logic [CNT_W-1:0]       match_count
);

    localparam int HW = PATTERN_LEN - 1;
    localparam int FW = (PATTERN_LEN > 2) ? $clog2(PATTERN_LEN) : 1;
    localparam logic [FW-1:0]    FILL_MAX = FW'(PATTERN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [PATTERN_LEN-1:0] pattern_reg, pattern_nxt;
    logic [HW-1:0]          hist, hist_nxt;
    logic [FW-1:0]          fill, fill_nxt;
    logic                   out_nxt;
    logic [CNT_W-1:0]       count_nxt;

    logic                   accept;
    logic                   full;
    logic                   match;
    logic [PATTERN_LEN-1:0] cand;

    always_comb begin
        // A load on the same cycle as a valid bit discards the bit.
        accept = in_valid & ~pat_load;
        full   = (fill == FILL_MAX);
        cand   = {hist, in};
        match  = accept && full && (cand == pattern_reg);

        pattern_nxt = pattern_reg;
        hist_nxt    = hist;
        fill_nxt    = fill;
        out_nxt     = match;
        count_nxt   = match_count;

        if (pat_load) begin
            pattern_nxt = pattern;
            hist_nxt    = '0;
            fill_nxt    = '0;
        end else if (in_valid) begin
            if (match && !OVERLAP) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                hist_nxt = cand[HW-1:0];
                fill_nxt = full ? fill : fill + FW'(1);
            end
        end

        // Clear has priority over a coincident match.
        if (cnt_clr) begin
            count_nxt = '0;
        end else if (match && (match_count != CNT_MAX)) begin
            count_nxt = match_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_reg <= DEFAULT_PATTERN;
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
        end else begin
            pattern_reg <= pattern_nxt;
            hist        <= hist_nxt;
            fill        <= fill_nxt;
            out         <= out_nxt;
            match_count <= count_nxt;
        end
    end

endmodule
